// File: rtl/debug_dump_engine.sv
// Debug register dump engine: snapshots the fetch PC and every register
// through the debug select port, then streams a checksummed byte frame.
module debug_dump_engine #(
  parameter int         NUM_REGS      = 16,
  parameter int         SETTLE_CYCLES = 1,
  parameter logic [7:0] HDR_BYTE      = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [3:0]  debug_reg_select,
  input  logic [31:0] debug_reg_data,
  input  logic [31:0] fetchPC,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_PCW  = 3'd2;
  localparam logic [2:0] S_SEL  = 3'd3;
  localparam logic [2:0] S_CAP  = 3'd4;
  localparam logic [2:0] S_WORD = 3'd5;
  localparam logic [2:0] S_CSUM = 3'd6;
  localparam logic [2:0] S_FIN  = 3'd7;

  localparam logic [3:0] LAST_SEL = 4'(NUM_REGS - 1);
  localparam logic [3:0] SETTLE   = 4'(SETTLE_CYCLES);

  logic [2:0]  r_state;
  logic [31:0] r_word;
  logic [7:0]  r_csum;
  logic [1:0]  r_bcnt;
  logic [3:0]  r_sel;
  logic [3:0]  r_cnt;

  logic        w_xfer;
  logic [31:0] w_shift;
  logic [7:0]  w_byte;

  assign w_shift = r_word >> {r_bcnt, 3'b000};
  assign w_byte  = w_shift[7:0];
  assign w_xfer  = out_valid & out_ready;

  assign debug_reg_select = r_sel;
  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_FIN);

  always_comb begin
    out_valid = 1'b0;
    out_data  = 8'h00;
    case (r_state)
      S_HDR: begin
        out_valid = 1'b1;
        out_data  = HDR_BYTE;
      end
      S_PCW, S_WORD: begin
        out_valid = 1'b1;
        out_data  = w_byte;
      end
      S_CSUM: begin
        out_valid = 1'b1;
        out_data  = r_csum;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_word  <= '0;
      r_csum  <= '0;
      r_bcnt  <= '0;
      r_sel   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_word  <= fetchPC;
            r_csum  <= '0;
            r_bcnt  <= '0;
            r_state <= S_HDR;
          end
        end
        S_HDR: begin
          if (w_xfer) r_state <= S_PCW;
        end
        S_PCW, S_WORD: begin
          if (w_xfer) begin
            r_csum <= r_csum ^ w_byte;
            r_bcnt <= r_bcnt + 2'd1;
            if (r_bcnt == 2'd3) begin
              // PC done: start at register 0; else advance or finish
              if (r_state == S_PCW) begin
                r_sel   <= '0;
                r_cnt   <= SETTLE;
                r_state <= S_SEL;
              end else if (r_sel != LAST_SEL) begin
                r_sel   <= r_sel + 4'd1;
                r_cnt   <= SETTLE;
                r_state <= S_SEL;
              end else begin
                r_state <= S_CSUM;
              end
            end
          end
        end
        S_SEL: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= S_CAP;
        end
        S_CAP: begin
          r_word  <= debug_reg_data;
          r_state <= S_WORD;
        end
        S_CSUM: begin
          if (w_xfer) r_state <= S_FIN;
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_dump_engine.sv
// Scoreboard bench for debug_dump_engine: frames predicted from the
// register/PC values, checked byte by byte by an independent monitor.
module tb_debug_dump_engine;

  localparam int NR = 16;
  localparam int ST = 3;

  typedef struct packed {
    logic [7:0] d;
    logic       last;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic [31:0] pc = 32'h0000_0040;
  logic        out_ready = 1'b1;
  logic        bp = 1'b0;
  logic        use_b = 1'b0;

  logic [3:0]  sel_a, sel_b;
  logic [31:0] data_a, data_b;
  logic [7:0]  od_a, od_b, od;
  logic        ov_a, ov_b, ov;
  logic        busy_a, busy_b, bsy;
  logic        done_a, done_b, dn;

  logic [31:0] regv [16];
  int          stab = 0;
  logic [3:0]  last_sel = 4'h0;

  exp_t        q[$];
  exp_t        e;
  int          n_chk = 0;
  int          n_fail = 0;
  int          nbytes = 0;
  logic        pend = 1'b0;
  logic        stall_prev = 1'b0;
  logic [7:0]  prev_d = 8'h00;
  logic        exp_busy = 1'b0;
  int          cyc;

  always #5 clk = ~clk;

  debug_dump_engine #(
    .NUM_REGS(NR), .SETTLE_CYCLES(ST), .HDR_BYTE(8'hA5)
  ) u_dut (
    .clk(clk), .reset(reset), .start(start_a),
    .debug_reg_select(sel_a), .debug_reg_data(data_a),
    .fetchPC(pc), .out_data(od_a), .out_valid(ov_a),
    .out_ready(out_ready), .busy(busy_a), .done(done_a)
  );

  debug_dump_engine #(
    .NUM_REGS(1), .SETTLE_CYCLES(1), .HDR_BYTE(8'hA5)
  ) u_one (
    .clk(clk), .reset(reset), .start(start_b),
    .debug_reg_select(sel_b), .debug_reg_data(data_b),
    .fetchPC(pc), .out_data(od_b), .out_valid(ov_b),
    .out_ready(out_ready), .busy(busy_b), .done(done_b)
  );

  // Register file stub: a word is only valid once the select has settled
  assign data_a = (stab >= ST) ? regv[sel_a] : 32'h0;
  assign data_b = regv[sel_b];

  assign od  = use_b ? od_b   : od_a;
  assign ov  = use_b ? ov_b   : ov_a;
  assign bsy = use_b ? busy_b : busy_a;
  assign dn  = use_b ? done_b : done_a;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
               $time);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    exp_t x;
    x.d = d;
    x.last = l;
    q.push_back(x);
  endtask

  task automatic push_frame(input logic [31:0] p, input int nr);
    logic [7:0]  cs;
    logic [31:0] w;
    cs = 8'h00;
    push(8'hA5, 1'b0);
    for (int r = -1; r < nr; r++) begin
      if (r < 0) w = p;
      else w = regv[r];
      for (int b = 0; b < 4; b++) begin
        cs = cs ^ w[8*b +: 8];
        push(w[8*b +: 8], 1'b0);
      end
    end
    push(cs, 1'b1);
  endtask

  task automatic start_frame(input bit b, input int nr);
    @(posedge clk);
    #1;
    pc = $urandom;
    push_frame(pc, nr);
    if (b) start_b = 1'b1;
    else start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    exp_busy = 1'b1;
    pc = $urandom;
  endtask

  task automatic wait_done(input int budget, output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!dn && c < budget);
    if (!dn) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_bytes(input int n);
    int k;
    k = 0;
    while (nbytes < n && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (nbytes < n) chk("byte_timeout", nbytes, n);
  endtask

  task automatic rand_regs();
    for (int i = 0; i < 16; i++) regv[i] = $urandom;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sel_a != last_sel) begin
        stab = 1;
        last_sel = sel_a;
      end else if (stab < 1000) begin
        stab++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every transfer
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("done", {31'd0, dn}, {31'd0, pend});
        chk("busy", {31'd0, bsy}, {31'd0, exp_busy});
        if (pend) exp_busy = 1'b0;
        if (stall_prev) chk("hold", {23'd0, ov, od}, {23'd0, 1'b1, prev_d});
        if (use_b) chk("sel_b", {28'd0, sel_b}, 32'd0);
        pend = 1'b0;
        if (ov && out_ready) begin
          nbytes++;
          if (q.size() == 0) begin
            chk("extra_byte", {24'd0, od}, 32'hFFFF_FFFF);
          end else begin
            e = q.pop_front();
            chk("byte", {24'd0, od}, {24'd0, e.d});
            pend = e.last;
          end
        end
        stall_prev = ov && !out_ready;
        prev_d = od;
      end else begin
        pend = 1'b0;
        stall_prev = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) regv[i] = 32'h1000_0000 + i;
    #1;
    chk("rst_state",
        {17'd0, sel_a, od_a, ov_a, busy_a, done_a}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // basic dump with known register pattern, full throughput timing
    start_frame(0, NR);
    wait_done(400, cyc);
    chk("frame_cycles", cyc, 1 + 4 + NR * (ST + 1 + 4) + 1 + 1);
    chk("drain_basic", q.size(), 0);

    // backpressure with random data
    for (int f = 0; f < 2; f++) begin
      rand_regs();
      bp = 1'b1;
      start_frame(0, NR);
      wait_done(3000, cyc);
      chk("drain_bp", q.size(), 0);
      bp = 1'b0;
    end

    // start while busy and on the done cycle must be ignored
    rand_regs();
    nbytes = 0;
    start_frame(0, NR);
    wait_bytes(10);
    @(posedge clk);
    #1;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    wait_done(400, cyc);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    repeat (20) @(negedge clk);
    chk("no_restart", {30'd0, ov_a, busy_a}, 32'd0);
    chk("drain_busy", q.size(), 0);

    // reset mid-frame: outputs clear without an edge
    rand_regs();
    nbytes = 0;
    start_frame(0, NR);
    wait_bytes(20);
    #2;
    reset = 1'b0;
    q.delete();
    exp_busy = 1'b0;
    #1;
    chk("rst_mid",
        {17'd0, sel_a, od_a, ov_a, busy_a, done_a}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    bp = 1'b1;
    start_frame(0, NR);
    wait_done(3000, cyc);
    chk("drain_rst", q.size(), 0);
    bp = 1'b0;

    // single-register configuration
    use_b = 1'b1;
    rand_regs();
    start_frame(1, 1);
    wait_done(100, cyc);
    chk("frame_cycles_1", cyc, 1 + 4 + 1 * (1 + 1 + 4) + 1 + 1);
    chk("drain_one", q.size(), 0);
    bp = 1'b1;
    start_frame(1, 1);
    wait_done(400, cyc);
    chk("drain_one_bp", q.size(), 0);
    bp = 1'b0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
